// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: loader start, program memory read port, decoder handshake and branch redirect.
// Trits are 2-bit codes: 2'b10 = -1, 2'b00 = 0, 2'b01 = +1; trit 0 sits in bits [1:0].
interface instruction_fetch_unit_if #(
  parameter int WORD_SIZE     = 9,
  parameter int MEM_ADDR_SIZE = 6
);
  logic                         start;
  logic [2*MEM_ADDR_SIZE-1:0]   mem_addr;
  logic                         mem_read;
  logic [2*WORD_SIZE-1:0]       mem_read_data;
  logic [2*WORD_SIZE-1:0]       instr_out;
  logic                         instr_valid;
  logic                         instr_ready;
  logic                         branch_taken;
  logic [2*MEM_ADDR_SIZE-1:0]   branch_target;
  logic [2*MEM_ADDR_SIZE-1:0]   pc;
  logic                         halted;

  modport master (
    input  start, mem_read_data, instr_ready, branch_taken, branch_target,
    output mem_addr, mem_read, instr_out, instr_valid, pc, halted
  );

  modport slave (
    output start, mem_read_data, instr_ready, branch_taken, branch_target,
    input  mem_addr, mem_read, instr_out, instr_valid, pc, halted
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Ternary fetch stage: walks program memory from the minimum balanced-ternary address upward,
// hands each word to the decoder over valid/ready, follows branch redirects, halts after the top address.
module instruction_fetch_unit #(
  parameter int WORD_SIZE     = 9,
  parameter int MEM_ADDR_SIZE = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  instruction_fetch_unit_if.master bus
);
  // state | meaning
  // IDLE  | waiting for the loader to finish
  // REQ   | read strobe issued at pc
  // WAIT  | memory returns the word; capture it
  // HOLD  | word offered to the decoder until accepted
  // HALT  | top address consumed; frozen until reset
  localparam int AW = 2*MEM_ADDR_SIZE;
  localparam int DW = 2*WORD_SIZE;
  localparam logic [1:0] TRIT_NEG  = 2'b10;
  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [AW-1:0] ADDR_MIN = {MEM_ADDR_SIZE{TRIT_NEG}};
  localparam logic [AW-1:0] ADDR_MAX = {MEM_ADDR_SIZE{TRIT_POS}};

  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_HOLD, ST_HALT} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [DW-1:0]   instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;
  logic [AW-1:0]   pc_inc;

  // Zero trits above pc never change the low trits of a +1, and the carry out of the
  // top trit only appears on wrap past the maximum, which the FSM never takes.
  function automatic logic [AW-1:0] trit_inc(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    logic          carry;
    r     = a;
    carry = 1'b1;
    for (int i = 0; i < MEM_ADDR_SIZE; i++) begin
      if (carry) begin
        case (a[2*i +: 2])
          TRIT_NEG:  begin r[2*i +: 2] = TRIT_ZERO; carry = 1'b0; end
          TRIT_ZERO: begin r[2*i +: 2] = TRIT_POS;  carry = 1'b0; end
          default:   begin r[2*i +: 2] = TRIT_NEG;  carry = 1'b1; end
        endcase
      end
    end
    return r;
  endfunction

  assign pc_inc = trit_inc(pc_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= ADDR_MIN;
      instr_q  <= {WORD_SIZE{TRIT_ZERO}};
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_REQ;
          pc_d    = ADDR_MIN;
        end
      end
      ST_REQ, ST_WAIT, ST_HOLD: begin
        // A redirect beats a same-cycle handshake: the held word is dropped, not delivered.
        if (bus.branch_taken) begin
          pc_d    = bus.branch_target;
          valid_d = 1'b0;
          state_d = ST_REQ;
        end else if (state_q == ST_REQ) begin
          state_d = ST_WAIT;
        end else if (state_q == ST_WAIT) begin
          instr_d = bus.mem_read_data;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else if (bus.instr_ready) begin
          valid_d = 1'b0;
          if (pc_q == ADDR_MAX) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            pc_d    = pc_inc;
            state_d = ST_REQ;
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.mem_addr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.mem_read    = (state_q == ST_REQ);
  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = halted_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 9-word ternary memory holding each address's own value.
module tb_instruction_fetch_unit;
  localparam int MAS = 2;
  localparam int WS  = 3;
  localparam int AW  = 2*MAS;
  localparam int DW  = 2*WS;
  localparam logic [1:0] T_NEG  = 2'b10;
  localparam logic [1:0] T_ZERO = 2'b00;
  localparam logic [1:0] T_POS  = 2'b01;
  localparam logic [AW-1:0] A_MIN = 4'b1010;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  instruction_fetch_unit_if #(.WORD_SIZE(WS), .MEM_ADDR_SIZE(MAS)) bus ();
  instruction_fetch_unit #(.WORD_SIZE(WS), .MEM_ADDR_SIZE(MAS)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  // Memory: data for the address strobed this cycle appears after the edge; word(a) = a.
  always @(posedge clock)
    if (bus.mem_read) bus.mem_read_data <= {{(DW-AW){1'b0}}, bus.mem_addr};

  int n_cmp = 0;
  int n_bad = 0;
  int got[$];
  int got_cyc[$];
  int halt_cyc;

  function automatic int tdec(input logic [DW-1:0] v);
    int s = 0;
    int w = 1;
    for (int i = 0; i < WS; i++) begin
      case (v[2*i +: 2])
        T_POS:   s += w;
        T_NEG:   s -= w;
        T_ZERO:  ;
        default: s += 1000;
      endcase
      w *= 3;
    end
    return s;
  endfunction

  function automatic int adec(input logic [AW-1:0] a);
    return tdec({{(DW-AW){1'b0}}, a});
  endfunction

  function automatic logic [DW-1:0] tenc(input int v);
    logic [DW-1:0] r = '0;
    int t;
    for (int i = 0; i < WS; i++) begin
      t = v % 3;
      if (t == 2)  t = -1;
      if (t == -2) t = 1;
      r[2*i +: 2] = (t == 1) ? T_POS : ((t == -1) ? T_NEG : T_ZERO);
      v = (v - t) / 3;
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_target(input int t);
    logic [DW-1:0] w;
    w = tenc(t);
    bus.branch_target = w[AW-1:0];
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.start = 1'b0; bus.instr_ready = 1'b0; bus.branch_taken = 1'b0;
    set_target(0);
    step();
    reset = 1'b1;
    step();
  endtask

  // Records every handshake (valid with ready held high) until halted or the budget expires.
  task automatic collect(input int budget);
    got.delete();
    got_cyc.delete();
    halt_cyc = -1;
    for (int c = 0; c < budget; c++) begin
      if (bus.halted) begin
        halt_cyc = c;
        break;
      end
      if (bus.instr_valid && bus.instr_ready) begin
        got.push_back(tdec(bus.instr_out));
        got_cyc.push_back(c);
      end
      step();
    end
    chk("collect_reaches_halt", int'(bus.halted), 1);
  endtask

  task automatic wait_read_at(input int a, input string name);
    int found = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.mem_read && adec(bus.mem_addr) == a) begin
        found = 1;
        break;
      end
      step();
    end
    chk(name, found, 1);
  endtask

  typedef struct {
    logic start; logic ready; logic br; int tgt;
    logic e_rd; int e_addr; logic e_val; int e_instr; logic e_halt;
  } vec_t;

  localparam int NV = 21;
  vec_t vt[NV];

  initial begin
    int rd;
    int found;
    //          start ready br tgt   rd addr val instr halt
    vt[0]  = '{1'b1, 1'b0, 1'b0,  0, 1'b1, -4, 1'b0,  0, 1'b0};
    vt[1]  = '{1'b0, 1'b0, 1'b0,  0, 1'b0, -4, 1'b0,  0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 1'b0,  0, 1'b0, -4, 1'b1, -4, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 1'b0,  0, 1'b0, -4, 1'b1, -4, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 1'b0,  0, 1'b0, -4, 1'b1, -4, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 1'b0,  0, 1'b0, -4, 1'b1, -4, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 1'b0,  0, 1'b0, -4, 1'b1, -4, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 1'b0,  0, 1'b0, -4, 1'b1, -4, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 1'b0,  0, 1'b1, -3, 1'b0,  0, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 1'b0,  0, 1'b0, -3, 1'b0,  0, 1'b0};
    vt[10] = '{1'b0, 1'b1, 1'b0,  0, 1'b0, -3, 1'b1, -3, 1'b0};
    vt[11] = '{1'b0, 1'b1, 1'b0,  0, 1'b1, -2, 1'b0,  0, 1'b0};
    vt[12] = '{1'b0, 1'b1, 1'b1,  3, 1'b1,  3, 1'b0,  0, 1'b0};
    vt[13] = '{1'b0, 1'b1, 1'b0,  0, 1'b0,  3, 1'b0,  0, 1'b0};
    vt[14] = '{1'b0, 1'b1, 1'b0,  0, 1'b0,  3, 1'b1,  3, 1'b0};
    vt[15] = '{1'b0, 1'b1, 1'b0,  0, 1'b1,  4, 1'b0,  0, 1'b0};
    vt[16] = '{1'b0, 1'b1, 1'b0,  0, 1'b0,  4, 1'b0,  0, 1'b0};
    vt[17] = '{1'b0, 1'b0, 1'b0,  0, 1'b0,  4, 1'b1,  4, 1'b0};
    vt[18] = '{1'b0, 1'b0, 1'b0,  0, 1'b0,  4, 1'b1,  4, 1'b0};
    vt[19] = '{1'b0, 1'b1, 1'b0,  0, 1'b0,  4, 1'b0,  0, 1'b1};
    vt[20] = '{1'b1, 1'b1, 1'b1,  0, 1'b0,  4, 1'b0,  0, 1'b1};

    bus.start = 1'b0; bus.instr_ready = 1'b0; bus.branch_taken = 1'b0;
    set_target(0);
    step();
    step();
    chk("rst_mem_read", int'(bus.mem_read), 0);
    chk("rst_valid", int'(bus.instr_valid), 0);
    chk("rst_halted", int'(bus.halted), 0);
    chk("rst_pc", int'(bus.pc), int'(A_MIN));
    chk("rst_instr", int'(bus.instr_out), 0);
    reset = 1'b1;
    step();
    chk("idle_no_read", int'(bus.mem_read), 0);

    // Backpressure, branch in REQ, halt at the top address, halt immunity.
    for (int i = 0; i < NV; i++) begin
      bus.start = vt[i].start;
      bus.instr_ready = vt[i].ready;
      bus.branch_taken = vt[i].br;
      set_target(vt[i].tgt);
      step();
      chk($sformatf("vec%0d_mem_read", i), int'(bus.mem_read), int'(vt[i].e_rd));
      chk($sformatf("vec%0d_addr", i), adec(bus.mem_addr), vt[i].e_addr);
      chk($sformatf("vec%0d_pc", i), adec(bus.pc), vt[i].e_addr);
      chk($sformatf("vec%0d_valid", i), int'(bus.instr_valid), int'(vt[i].e_val));
      chk($sformatf("vec%0d_halted", i), int'(bus.halted), int'(vt[i].e_halt));
      if (vt[i].e_val) chk($sformatf("vec%0d_instr", i), tdec(bus.instr_out), vt[i].e_instr);
    end

    // Sequential fetch with ready held high.
    do_reset();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.instr_ready = 1'b1;
    collect(60);
    chk("seq_count", got.size(), 9);
    for (int i = 0; i < got.size() && i < 9; i++) chk($sformatf("seq_word%0d", i), got[i], i - 4);
    for (int i = 1; i < got_cyc.size(); i++) chk($sformatf("seq_gap%0d", i), got_cyc[i] - got_cyc[i-1], 3);
    if (got_cyc.size() > 0) chk("seq_halt_edge", halt_cyc, got_cyc[got_cyc.size()-1] + 1);
    rd = 0;
    repeat (10) begin
      if (bus.mem_read) rd++;
      step();
    end
    chk("seq_reads_after_halt", rd, 0);
    chk("seq_halted_sticky", int'(bus.halted), 1);

    // Branch in HOLD with ready in the same cycle.
    do_reset();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.instr_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.instr_valid && tdec(bus.instr_out) == -3) begin
        found = 1;
        break;
      end
      step();
    end
    chk("hold_found_m3", found, 1);
    bus.branch_taken = 1'b1;
    set_target(2);
    step();
    bus.branch_taken = 1'b0;
    chk("hold_br_valid", int'(bus.instr_valid), 0);
    chk("hold_br_read", int'(bus.mem_read), 1);
    chk("hold_br_addr", adec(bus.mem_addr), 2);
    collect(40);
    chk("hold_br_count", got.size(), 3);
    for (int i = 0; i < got.size() && i < 3; i++) chk($sformatf("hold_br_word%0d", i), got[i], i + 2);

    // Branch in WAIT for address 0.
    do_reset();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.instr_ready = 1'b1;
    wait_read_at(0, "wait_found_req0");
    step();
    chk("wait_in_wait", int'(bus.mem_read), 0);
    bus.branch_taken = 1'b1;
    set_target(-4);
    step();
    bus.branch_taken = 1'b0;
    chk("wait_br_valid", int'(bus.instr_valid), 0);
    chk("wait_br_addr", adec(bus.mem_addr), -4);
    collect(60);
    chk("wait_br_count", got.size(), 9);
    if (got.size() > 0) chk("wait_br_first", got[0], -4);

    // Asynchronous reset during WAIT.
    do_reset();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.instr_ready = 1'b1;
    wait_read_at(-3, "rst_found_req_m3");
    step();
    chk("rst_pre_instr", tdec(bus.instr_out), -4);
    #2 reset = 1'b0;
    #1;
    chk("arst_mem_read", int'(bus.mem_read), 0);
    chk("arst_valid", int'(bus.instr_valid), 0);
    chk("arst_halted", int'(bus.halted), 0);
    chk("arst_pc", int'(bus.pc), int'(A_MIN));
    chk("arst_instr", int'(bus.instr_out), 0);
    step();
    reset = 1'b1;
    step();
    chk("arst_idle", int'(bus.mem_read), 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("arst_restart_read", int'(bus.mem_read), 1);
    chk("arst_restart_addr", adec(bus.mem_addr), -4);
    collect(60);
    chk("arst_count", got.size(), 9);
    if (got.size() > 0) chk("arst_first", got[0], -4);

    // Halt immunity, then async reset clears halted.
    rd = 0;
    for (int c = 0; c < 6; c++) begin
      bus.start = c[0];
      bus.branch_taken = (c == 1);
      set_target(0);
      step();
      if (bus.mem_read) rd++;
    end
    bus.branch_taken = 1'b0;
    chk("halt_imm_reads", rd, 0);
    chk("halt_imm_halted", int'(bus.halted), 1);
    chk("halt_imm_pc", adec(bus.pc), 4);
    #2 reset = 1'b0;
    #1;
    chk("halt_arst_halted", int'(bus.halted), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
